// File: rtl/fish_sprite_reader.sv
// fish_sprite_reader
//
// Pixel-side reader for a 16x32 fish sprite ROM with a one-clock read
// latency. Once per frame the fish moves horizontally between X_MIN and
// X_MAX. For every incoming pixel the block decides whether the pixel is
// inside the fish box and drives the matching ROM row/col. It then aligns
// the hit flag with the ROM latency and masks out the transparent key colour.
//
// Optional feature: define FISH_MIRROR_EN to mirror the sprite horizontally
// while the fish swims left, so it always faces its travel direction.
//
// Ports:
//   clk        system clock, all logic on rising edge
//   reset      synchronous, active-high reset
//   x, y       current pixel column/row from the sync generator
//   video_on   active-display flag for x/y
//   freeze     hold the fish in place (hooked)
//   rom_row    row address to the sprite ROM (0 outside the fish box)
//   rom_col    column address to the sprite ROM (0 outside the fish box)
//   rom_data   ROM colour, valid one clock after the address
//   fish_on    pixel presented one clock earlier is opaque fish
//   fish_rgb   colour for that pixel, 12'h000 when fish_on = 0
//   fish_x     current fish left edge
//   dir_left   1 = swimming left (also while frozen after swimming left)
//   state_dbg  movement FSM state (0 = SWIM_R, 1 = SWIM_L, 2 = FROZEN)

module fish_sprite_reader #(
    parameter logic [9:0]  X_MIN     = 10'd0,
    parameter logic [9:0]  X_MAX     = 10'd608,
    parameter logic [9:0]  Y_POS     = 10'd300,
    parameter logic [2:0]  SPEED     = 3'd2,
    parameter logic [11:0] KEY_COLOR = 12'h0F0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic        freeze,
    output logic [3:0]  rom_row,
    output logic [4:0]  rom_col,
    input  logic [11:0] rom_data,
    output logic        fish_on,
    output logic [11:0] fish_rgb,
    output logic [9:0]  fish_x,
    output logic        dir_left,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        SWIM_R = 2'd0,
        SWIM_L = 2'd1,
        FROZEN = 2'd2
    } state_t;

    state_t state;
    logic   saved_left;   // direction to resume after FROZEN
    logic   tick;         // one-cycle frame pulse, registered
    logic   hit;
    logic   hit_d;        // hit aligned with the ROM read latency

    // 11-bit copies so box-edge sums cannot overflow.
    logic [10:0] x_w, y_w, fx_w, ypos_w, xmin_w, xmax_w, spd_w;

    assign x_w    = {1'b0, x};
    assign y_w    = {1'b0, y};
    assign fx_w   = {1'b0, fish_x};
    assign ypos_w = {1'b0, Y_POS};
    assign xmin_w = {1'b0, X_MIN};
    assign xmax_w = {1'b0, X_MAX};
    assign spd_w  = {8'd0, SPEED};

    assign hit = video_on
              && (x_w >= fx_w)   && (x_w < fx_w + 11'd32)
              && (y_w >= ypos_w) && (y_w < ypos_w + 11'd16);

    // Only the low bits of the offsets matter: inside the box they are
    // exactly the sprite coordinates.
    logic [4:0] off_col;
    logic [3:0] off_row;

    assign off_col = x[4:0] - fish_x[4:0];
    assign off_row = y[3:0] - Y_POS[3:0];

    always_comb begin
        rom_row = 4'd0;
        rom_col = 5'd0;
        if (hit) begin
            rom_row = off_row;
`ifdef FISH_MIRROR_EN
            rom_col = dir_left ? (5'd31 - off_col) : off_col;
`else
            rom_col = off_col;
`endif
        end
    end

    assign fish_on  = hit_d && (rom_data != KEY_COLOR);
    assign fish_rgb = fish_on ? rom_data : 12'h000;

    assign dir_left  = (state == SWIM_L) || ((state == FROZEN) && saved_left);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SWIM_R;
            saved_left <= 1'b0;
            fish_x     <= X_MIN;
            tick       <= 1'b0;
            hit_d      <= 1'b0;
        end else begin
            tick  <= (x == 10'd0) && (y == 10'd481);
            hit_d <= hit;
            case (state)
                SWIM_R: begin
                    // freeze has priority over a coincident tick
                    if (freeze) begin
                        state      <= FROZEN;
                        saved_left <= 1'b0;
                    end else if (tick) begin
                        if (fx_w + spd_w >= xmax_w) begin
                            fish_x <= X_MAX;
                            state  <= SWIM_L;
                        end else begin
                            fish_x <= fish_x + {7'd0, SPEED};
                        end
                    end
                end
                SWIM_L: begin
                    if (freeze) begin
                        state      <= FROZEN;
                        saved_left <= 1'b1;
                    end else if (tick) begin
                        if (fx_w <= xmin_w + spd_w) begin
                            fish_x <= X_MIN;
                            state  <= SWIM_R;
                        end else begin
                            fish_x <= fish_x - {7'd0, SPEED};
                        end
                    end
                end
                FROZEN: begin
                    // position holds; movement resumes at the next tick
                    if (!freeze) begin
                        state <= saved_left ? SWIM_L : SWIM_R;
                    end
                end
                default: begin
                    state <= SWIM_R;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fish_sprite_reader.sv
// tb_fish_sprite_reader
//
// Bench for fish_sprite_reader with default parameters. A registered ROM
// model answers the DUT's addresses. A behavioural model tracks the fish
// position, direction and frozen flag from the movement rules. It also
// predicts addresses and pixel outputs. A negedge process compares every
// cycle, and directed sequences pin the model with literal values.

module tb_fish_sprite_reader;

    localparam int X_MIN = 0;
    localparam int X_MAX = 608;
    localparam int Y_POS = 300;
    localparam int SPEED = 2;
    localparam logic [11:0] KEY = 12'h0F0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic        video_on = 1'b0;
    logic        freeze = 1'b0;
    logic [3:0]  rom_row;
    logic [4:0]  rom_col;
    logic [11:0] rom_data = '0;
    logic        fish_on;
    logic [11:0] fish_rgb;
    logic [9:0]  fish_x;
    logic        dir_left;
    logic [1:0]  state_dbg;

    int n_cmp = 0;
    int n_fail = 0;
    bit check_en = 1'b0;
    bit rom_sparse = 1'b0;

    fish_sprite_reader dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .video_on  (video_on),
        .freeze    (freeze),
        .rom_row   (rom_row),
        .rom_col   (rom_col),
        .rom_data  (rom_data),
        .fish_on   (fish_on),
        .fish_rgb  (fish_rgb),
        .fish_x    (fish_x),
        .dir_left  (dir_left),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- ROM contents and model ----------------
    function automatic logic [11:0] rom_fn(input int r, input int c);
        logic [3:0] rr;
        logic [4:0] cc;
        rr = r[3:0];
        cc = c[4:0];
        if (rom_sparse)
            return (r == 3 && c == 5) ? 12'h88F : KEY;
        if ((r + c) % 4 == 0)
            return KEY;
        return {3'b101, rr, cc};
    endfunction

    always @(posedge clk) rom_data <= rom_fn(int'(rom_row), int'(rom_col));

    // ---------------- behavioural reference ----------------
    int m_x = X_MIN;
    bit m_left = 1'b0;
    bit m_frozen = 1'b0;
    bit m_tick = 1'b0;
    bit m_hit_d = 1'b0;
    logic [11:0] m_data = '0;

    function automatic bit in_box(input int xi, input int yi, input bit von, input int mx);
        return von && xi >= mx && xi < mx + 32 && yi >= Y_POS && yi < Y_POS + 16;
    endfunction

    task automatic exp_addr(input int xi, input int yi, input bit von, input int mx,
                            input bit ml, output int r, output int c);
        r = 0;
        c = 0;
        if (in_box(xi, yi, von, mx)) begin
            r = yi - Y_POS;
            c = xi - mx;
`ifdef FISH_MIRROR_EN
            if (ml) c = 31 - c;
`endif
        end
    endtask

    always @(posedge clk) begin
        int r, c;
        if (reset) begin
            m_x = X_MIN; m_left = 1'b0; m_frozen = 1'b0;
            m_tick = 1'b0; m_hit_d = 1'b0;
        end else begin
            exp_addr(int'(x), int'(y), video_on, m_x, m_left, r, c);
            m_hit_d = in_box(int'(x), int'(y), video_on, m_x);
            m_data = rom_fn(r, c);
            if (m_frozen) begin
                if (!freeze) m_frozen = 1'b0;
            end else if (freeze) begin
                m_frozen = 1'b1;
            end else if (m_tick) begin
                if (!m_left) begin
                    if (m_x + SPEED >= X_MAX) begin m_x = X_MAX; m_left = 1'b1; end
                    else m_x = m_x + SPEED;
                end else begin
                    if (m_x <= X_MIN + SPEED) begin m_x = X_MIN; m_left = 1'b0; end
                    else m_x = m_x - SPEED;
                end
            end
            m_tick = (x == 10'd0) && (y == 10'd481);
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int r, c;
        bit e_on;
        if (check_en) begin
            exp_addr(int'(x), int'(y), video_on, m_x, m_left, r, c);
            e_on = m_hit_d && (m_data != KEY);
            chk("rom_row", int'(rom_row), r);
            chk("rom_col", int'(rom_col), c);
            chk("fish_x", int'(fish_x), m_x);
            chk("dir_left", int'(dir_left), int'(m_left));
            chk("fish_on", int'(fish_on), int'(e_on));
            chk("fish_rgb", int'(fish_rgb), e_on ? int'(m_data) : 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // frame tick: x=0,y=481 for one pixel; fish_x moves one clock later
    task automatic do_tick();
        x = 10'd0; y = 10'd481; video_on = 1'b0;
        step();
        x = 10'd10; y = 10'd490;
        step();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cnt, px, py, prgb, rx;
        bit found;

        reset = 1'b1;
        step();
        check_en = 1'b1;
        step();
        chk("reset_fish_x", int'(fish_x), X_MIN);
        chk("reset_dir_left", int'(dir_left), 0);
        chk("reset_fish_on", int'(fish_on), 0);
        chk("reset_fish_rgb", int'(fish_rgb), 0);
        chk("reset_rom_row", int'(rom_row), 0);
        chk("reset_rom_col", int'(rom_col), 0);
        reset = 1'b0;
        step();

        // first frame with a single opaque texel at (3,5)
        rom_sparse = 1'b1;
        cnt = 0; px = -1; py = -1; prgb = 0;
        for (int yy = Y_POS - 1; yy <= Y_POS + 16; yy++) begin
            for (int xx = 0; xx <= 40; xx++) begin
                x = xx[9:0]; y = yy[9:0]; video_on = 1'b1;
                step();
                if (fish_on) begin
                    cnt++; px = xx; py = yy; prgb = int'(fish_rgb);
                end
            end
        end
        video_on = 1'b0;
        step();
        chk("single_pixel_count", cnt, 1);
        chk("single_pixel_x", px, X_MIN + 5);
        chk("single_pixel_y", py, Y_POS + 3);
        chk("single_pixel_rgb", prgb, 12'h88F);
        rom_sparse = 1'b0;

        // movement
        do_tick(); chk("tick1_x", int'(fish_x), 2);
        do_tick(); chk("tick2_x", int'(fish_x), 4);
        do_tick(); chk("tick3_x", int'(fish_x), 6);

        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            do_tick();
            if (dir_left) found = 1'b1;
        end
        chk("turn_reached", int'(found), 1);
        chk("turn_x", int'(fish_x), X_MAX);
        do_tick();
        chk("after_turn_x", int'(fish_x), X_MAX - 2);

        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (fish_x == 10'd100) found = 1'b1;
            else do_tick();
        end
        chk("reach_100", int'(found), 1);

        // frozen across five ticks
        freeze = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            do_tick();
            chk("frozen_x", int'(fish_x), 100);
            chk("frozen_dir", int'(dir_left), 1);
        end
        freeze = 1'b0;
        step();
        do_tick();
        chk("unfreeze_x", int'(fish_x), 98);

        // freeze in the same cycle as the registered tick
        x = 10'd0; y = 10'd481; video_on = 1'b0;
        step();
        x = 10'd10; y = 10'd490; freeze = 1'b1;
        step();
        freeze = 1'b0;
        step();
        chk("freeze_tick_x", int'(fish_x), 98);
        chk("freeze_tick_dir", int'(dir_left), 1);
        do_tick();
        chk("resume_x", int'(fish_x), 96);

        // column address for pixel fish_x+5 while swimming left
        x = fish_x + 10'd5; y = Y_POS[9:0]; video_on = 1'b1;
        #1;
`ifdef FISH_MIRROR_EN
        chk("mirror_col", int'(rom_col), 26);
`else
        chk("mirror_col", int'(rom_col), 5);
`endif
        step();

        // randomized pixels, freezes and ticks
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 4) begin
                x = 10'd0; y = 10'd481; video_on = 1'b0;
            end else begin
                rx = m_x - 4 + int'($urandom_range(0, 44));
                if (rx < 0) rx = 0;
                x = rx[9:0];
                y = 10'(Y_POS - 3 + int'($urandom_range(0, 21)));
                video_on = ($urandom_range(0, 7) != 0);
            end
            freeze = ($urandom_range(0, 9) == 0);
            step();
        end
        freeze = 1'b0;
        video_on = 1'b0;
        step();
        step();

        // reset while a fish pixel is in flight
        x = fish_x + 10'd1; y = Y_POS[9:0]; video_on = 1'b1;
        step();
        chk("pre_reset_fish_on", int'(fish_on), 1);
        reset = 1'b1;
        step();
        chk("mid_reset_fish_on", int'(fish_on), 0);
        chk("mid_reset_fish_rgb", int'(fish_rgb), 0);
        chk("mid_reset_fish_x", int'(fish_x), X_MIN);
        chk("mid_reset_dir", int'(dir_left), 0);
        reset = 1'b0;
        video_on = 1'b0;
        step();
        step();

        check_en = 1'b0;
        $display("final fsm state %0d", state_dbg);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // hard time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
